// File: rtl/host_if_pkg.sv
// host_if_pkg: shared opcodes, status codes, flag bits and master FSM states of the host link.
package host_if_pkg;

    localparam logic [3:0] CMD_PING  = 4'h0;
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_READ  = 4'h2;

    localparam logic [3:0] STS_PING  = 4'hF;
    localparam logic [3:0] STS_WRITE = 4'hE;
    localparam logic [3:0] STS_READ  = 4'hD;

    localparam int STS_ERR_BIT     = 4;
    localparam int FLAG_FIXED_ADDR = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_WR,
        S_WR_NEXT,
        S_WR_DRAIN,
        S_WB_RD,
        S_RD_OUT,
        S_RESP
    } state_t;

    // Status nibble is the bitwise inverse of the opcode, with the bus error flag above it.
    function automatic logic [31:0] make_status(input logic [3:0] op, input logic err);
        logic [31:0] s;
        s = {28'd0, ~op};
        s[STS_ERR_BIT] = err;
        return s;
    endfunction

endpackage

// File: rtl/wb_cmd_master_wb_single_cycle.sv
// wb_single_cycle: one Wishbone classic cycle per start pulse, aborted after WB_TIMEOUT ack-less cycles.
module wb_single_cycle #(
    parameter int WB_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        start,
    input  logic        start_we,
    input  logic [31:0] start_adr,
    input  logic [31:0] start_dat,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    logic        active;
    logic [15:0] cnt, cnt_inc;

    // cnt_inc is the number of cycles spent in the bus cycle including the current one.
    assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign done      = active && wbm_ack_i;
    assign err       = active && !wbm_ack_i && (cnt_inc == 16'(WB_TIMEOUT));
    assign rdata     = wbm_dat_i;
    assign wbm_cyc_o = active;
    assign wbm_stb_o = active;
    assign wbm_sel_o = active ? 4'hF : 4'h0;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            active    <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            cnt       <= '0;
        end else if (start) begin
            active    <= 1'b1;
            wbm_we_o  <= start_we;
            wbm_adr_o <= start_adr;
            wbm_dat_o <= start_dat;
            cnt       <= '0;
        end else if (done || err) begin
            active    <= 1'b0;
            wbm_we_o  <= 1'b0;
        end else if (active) begin
            cnt       <= cnt_inc;
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: executes host ping/write/read commands as single-word Wishbone cycles and returns responses.
module wb_cmd_master
    import host_if_pkg::*;
#(
    parameter int WB_TIMEOUT = 255,
    parameter int ADDR_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        master_ready,
    input  logic        ih_ready,
    input  logic        ih_reset,
    input  logic [31:0] in_command,
    input  logic [31:0] in_address,
    input  logic [27:0] in_data_count,
    input  logic [31:0] in_data,
    input  logic        oh_ready,
    output logic        oh_en,
    output logic [31:0] out_status,
    output logic [31:0] out_address,
    output logic [27:0] out_data_count,
    output logic [31:0] out_data,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    state_t      state, state_n;
    logic [3:0]  op, op_n;
    logic        fixed, fixed_n, err, err_n;
    logic [31:0] start_addr, start_addr_n, addr, addr_n, wdata, wdata_n, rdata, rdata_n, step;
    logic [27:0] words_left, words_left_n, out_data_count_n;
    logic [31:0] out_status_n, out_address_n, out_data_n;
    logic        master_ready_n, oh_en_n;
    logic        start, start_we, bus_done, bus_err;
    logic [31:0] bus_rdata;
    logic        cmd_unused;

    assign cmd_unused = ^{in_command[31:17], in_command[15:4]};
    assign step       = fixed ? 32'd0 : 32'(ADDR_STEP);

    always_ff @(posedge clk) begin
        if (rst || ih_reset) begin
            state          <= S_IDLE;
            op             <= '0;
            fixed          <= 1'b0;
            err            <= 1'b0;
            start_addr     <= '0;
            addr           <= '0;
            wdata          <= '0;
            rdata          <= '0;
            words_left     <= '0;
            master_ready   <= 1'b0;
            oh_en          <= 1'b0;
            out_status     <= '0;
            out_address    <= '0;
            out_data_count <= '0;
            out_data       <= '0;
        end else begin
            state          <= state_n;
            op             <= op_n;
            fixed          <= fixed_n;
            err            <= err_n;
            start_addr     <= start_addr_n;
            addr           <= addr_n;
            wdata          <= wdata_n;
            rdata          <= rdata_n;
            words_left     <= words_left_n;
            master_ready   <= master_ready_n;
            oh_en          <= oh_en_n;
            out_status     <= out_status_n;
            out_address    <= out_address_n;
            out_data_count <= out_data_count_n;
            out_data       <= out_data_n;
        end
    end

    always_comb begin
        state_n          = state;
        op_n             = op;
        fixed_n          = fixed;
        err_n            = err;
        start_addr_n     = start_addr;
        addr_n           = addr;
        wdata_n          = wdata;
        rdata_n          = rdata;
        words_left_n     = words_left;
        oh_en_n          = 1'b0;
        out_status_n     = out_status;
        out_address_n    = out_address;
        out_data_count_n = out_data_count;
        out_data_n       = out_data;
        case (state)
            S_IDLE: if (ih_ready) begin
                op_n         = in_command[3:0];
                fixed_n      = in_command[FLAG_FIXED_ADDR];
                err_n        = 1'b0;
                start_addr_n = in_address;
                addr_n       = in_address;
                wdata_n      = in_data;
                case (in_command[3:0])
                    CMD_PING:  begin state_n = S_RESP;  words_left_n = '0; end
                    CMD_WRITE: begin state_n = S_WB_WR; words_left_n = in_data_count; end
                    CMD_READ:  begin
                        state_n      = S_WB_RD;
                        words_left_n = (in_data_count == '0) ? '0 : in_data_count - 28'd1;
                    end
                    default: ;
                endcase
            end
            S_WB_WR: if (bus_done) begin
                state_n      = (words_left == '0) ? S_RESP : S_WR_NEXT;
                addr_n       = (words_left == '0) ? addr : addr + step;
                words_left_n = (words_left == '0) ? words_left : words_left - 28'd1;
            end else if (bus_err) begin
                err_n   = 1'b1;
                state_n = (words_left == '0) ? S_RESP : S_WR_DRAIN;
            end
            S_WR_NEXT: if (ih_ready) begin
                wdata_n = in_data;
                state_n = S_WB_WR;
            end
            S_WR_DRAIN: if (ih_ready) begin
                words_left_n = words_left - 28'd1;
                state_n      = (words_left <= 28'd1) ? S_RESP : S_WR_DRAIN;
            end
            S_WB_RD: if (bus_done) begin
                rdata_n = bus_rdata;
                state_n = S_RD_OUT;
            end else if (bus_err) begin
                rdata_n      = '0;
                err_n        = 1'b1;
                words_left_n = '0;
                state_n      = S_RD_OUT;
            end
            S_RD_OUT: if (oh_ready && !oh_en) begin
                oh_en_n          = 1'b1;
                out_status_n     = make_status(op, err);
                out_address_n    = start_addr;
                out_data_count_n = words_left;
                out_data_n       = rdata;
                state_n          = (words_left == '0) ? S_IDLE : S_WB_RD;
                addr_n           = (words_left == '0) ? addr : addr + step;
                words_left_n     = (words_left == '0) ? words_left : words_left - 28'd1;
            end
            S_RESP: if (oh_ready && !oh_en) begin
                oh_en_n          = 1'b1;
                out_status_n     = make_status(op, err);
                out_address_n    = start_addr;
                out_data_count_n = '0;
                out_data_n       = '0;
                state_n          = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        start          = (state_n == S_WB_WR && state != S_WB_WR) || (state_n == S_WB_RD && state != S_WB_RD);
        start_we       = (state_n == S_WB_WR);
        master_ready_n = (state_n == S_IDLE) || (state_n == S_WR_NEXT) || (state_n == S_WR_DRAIN);
    end

    wb_single_cycle #(.WB_TIMEOUT(WB_TIMEOUT)) u_bus (
        .clk       (clk),
        .rst       (rst),
        .abort     (ih_reset),
        .start     (start),
        .start_we  (start_we),
        .start_adr (addr_n),
        .start_dat (wdata_n),
        .done      (bus_done),
        .err       (bus_err),
        .rdata     (bus_rdata),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

endmodule
